// File: rtl/note_tone_divider.sv
// note_tone_divider: square-wave tone generator dividing the system clock by a key/octave period.
// Pitch updates only at period wrap so the waveform never emits a runt pulse.
module note_tone_divider #(
    parameter int CNT_W = 18,
    parameter int NKEYS = 13
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NKEYS-1:0] keys,
    input  logic [1:0]       oct_switch,
    output logic             wave,
    output logic             note_active,
    output logic [CNT_W-1:0] period
);
    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [15:0] BASE [13] = '{
        16'd38223, 16'd36078, 16'd34053, 16'd32141, 16'd30337, 16'd28634, 16'd27028,
        16'd25510, 16'd24079, 16'd22727, 16'd21452, 16'd20248, 16'd19111
    };

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, base, target;
    logic             wave_q, wave_d, note_active_q, note_active_d;
    logic [3:0]       sel;
    logic             any;

    // Highest set key wins, so scan upward and let later hits overwrite.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NKEYS; i++)
            if (keys[i]) sel = 4'(i);
    end

    assign any    = |keys;
    assign base   = CNT_W'(BASE[sel]);
    assign target = oct_switch == 2'b01 ? base << 1 : oct_switch == 2'b10 ? base << 2 : base;

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        period_d      = '0;
        note_active_d = 1'b0;
        if (!any) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d       = PLAY;
            period_d      = target;
            note_active_d = 1'b1;
        end else begin
            note_active_d = 1'b1;
            period_d      = cnt_q == period_q - 1'b1 ? target : period_q;
            cnt_d         = cnt_q == period_q - 1'b1 ? '0 : cnt_q + 1'b1;
        end
        wave_d = note_active_d && (cnt_d < (period_d >> 1));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_q      <= '0;
            wave_q        <= 1'b0;
            note_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            wave_q        <= wave_d;
            note_active_q <= note_active_d;
        end
    end

    assign wave        = wave_q;
    assign note_active = note_active_q;
    assign period      = period_q;
endmodule

// File: tb/tb_note_tone_divider.sv
// tb_note_tone_divider: directed scenarios with hand-computed periods and high/low times.
module tb_note_tone_divider;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [12:0] keys = '0;
    logic [1:0]  oct_switch = 2'b00;
    logic        wave, note_active;
    logic [17:0] period;
    int          passed = 0;
    int          total = 0;

    note_tone_divider dut (
        .clk(clk), .nrst(nrst), .keys(keys), .oct_switch(oct_switch),
        .wave(wave), .note_active(note_active), .period(period)
    );

    always #50 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic w, input logic n, input logic [17:0] p);
        total++;
        if (wave !== w || note_active !== n || period !== p)
            $display("FAIL %s: wave=%b note_active=%b period=%0d, required wave=%b note_active=%b period=%0d",
                     name, wave, note_active, period, w, n, p);
        else passed++;
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 1;
        for (int i = 0; i < 80000; i++) begin
            tick;
            if (wave !== lvl) break;
            n++;
        end
    endtask

    task automatic test_reset;
        int bad;
        #10 nrst = 1'b0;
        #1;
        expect_out("reset_async", 1'b0, 1'b0, 18'd0);
        repeat (3) tick;
        expect_out("reset_held", 1'b0, 1'b0, 18'd0);
        nrst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (wave !== 1'b0 || note_active !== 1'b0 || period !== 18'd0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL idle_hold: %0d bad cycles, required 0", bad);
        else passed++;
    endtask

    task automatic test_a4;
        int h, l;
        keys = 13'd1 << 9;
        tick;
        expect_out("a4_start", 1'b1, 1'b1, 18'd22727);
        count_level(1'b1, h);
        count_level(1'b0, l);
        total++;
        if (h != 11363 || l != 11364) $display("FAIL a4_duty: high=%0d low=%0d, required 11363/11364", h, l);
        else passed++;
        expect_out("a4_second_period", 1'b1, 1'b1, 18'd22727);
        keys = '0;
        tick;
        expect_out("a4_release", 1'b0, 1'b0, 18'd0);
    endtask

    task automatic test_c4;
        int h;
        oct_switch = 2'b10;
        keys = 13'd1;
        tick;
        expect_out("c4_oct10", 1'b1, 1'b1, 18'd152892);
        repeat (10) tick;
        expect_out("c4_oct10_high", 1'b1, 1'b1, 18'd152892);
        keys = '0;
        tick;
        expect_out("c4_release", 1'b0, 1'b0, 18'd0);
        oct_switch = 2'b11;
        keys = 13'd1;
        tick;
        expect_out("c4_oct11", 1'b1, 1'b1, 18'd38223);
        count_level(1'b1, h);
        total++;
        if (h != 19111) $display("FAIL c4_oct11_high: high=%0d, required 19111", h);
        else passed++;
        keys = '0;
        oct_switch = 2'b00;
        tick;
        expect_out("c4_oct11_release", 1'b0, 1'b0, 18'd0);
    endtask

    task automatic test_oct_switch;
        int bad;
        keys = 13'd1 << 9;
        tick;
        expect_out("sw_start", 1'b1, 1'b1, 18'd22727);
        bad = 0;
        for (int c = 1; c < 22727; c++) begin
            tick;
            if (wave !== (c < 11363) || period !== 18'd22727 || note_active !== 1'b1) bad++;
            if (c == 1000) keys = 13'd1 << 12;
            if (c == 1003) keys = 13'd1 << 9;
            if (c == 5000) oct_switch = 2'b01;
        end
        total++;
        if (bad != 0) $display("FAIL sw_no_runt: %0d bad cycles, required 0", bad);
        else passed++;
        tick;
        expect_out("sw_new_period", 1'b1, 1'b1, 18'd45454);
        keys = '0;
        oct_switch = 2'b00;
        tick;
        expect_out("sw_release", 1'b0, 1'b0, 18'd0);
    endtask

    task automatic test_multi_release;
        keys = (13'd1 << 2) | (13'd1 << 7);
        tick;
        expect_out("multi_g4", 1'b1, 1'b1, 18'd25510);
        repeat (100) tick;
        expect_out("multi_mid", 1'b1, 1'b1, 18'd25510);
        keys = '0;
        tick;
        expect_out("multi_release", 1'b0, 1'b0, 18'd0);
    endtask

    task automatic test_async_reset;
        int h;
        keys = 13'd1 << 9;
        tick;
        repeat (50) tick;
        expect_out("ar_playing", 1'b1, 1'b1, 18'd22727);
        #20 nrst = 1'b0;
        #1;
        expect_out("ar_async_clear", 1'b0, 1'b0, 18'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick;
        expect_out("ar_restart", 1'b1, 1'b1, 18'd22727);
        count_level(1'b1, h);
        total++;
        if (h != 11363) $display("FAIL ar_fresh_high: high=%0d, required 11363", h);
        else passed++;
        keys = '0;
        tick;
    endtask

    initial begin
        test_reset;
        test_a4;
        test_c4;
        test_oct_switch;
        test_multi_release;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
